if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Decoupling instruction buffer between the fetch stage and decode.
- Captures each fetched beat {pc, inst, snpc} into a small FIFO and presents the oldest entry to decode over a valid/ready handshake.
- Drops all buffered beats on a control-flow redirect (flush), so decode never sees wrong-path instructions.
- Fetch stalls when the FIFO is full, by deasserting in_ready toward the fetch stage's ready input.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, instruction driven on id_inst when the buffer is empty (addi x0,x0,0).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  fetch beat valid.
- in_ready  output  1  buffer can accept a beat.
- in_pc  input  32  fetch PC.
- in_inst  input  32  fetched instruction.
- in_snpc  input  32  in_pc + 4 from fetch.
- flush  input  1  redirect; discard all contents.
- id_valid  output  1  head entry valid toward decode.
- id_ready  input  1  decode accepts head.
- id_pc  output  32  head PC.
- id_inst  output  32  head instruction.
- id_snpc  output  32  head static next PC.

Behaviour:
- State:
  - Storage array of DEPTH x 96 bits.
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
- Reset (reset==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Storage contents are don't-care.
  - While reset is low: in_ready=0 and id_valid=0.
  - Reset mid-operation discards all entries.
- in_ready = reset & (count != DEPTH). Combinational from state only; no dependence on id_ready, so there is no full-bypass path.
- push = in_valid & in_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- On push:
  - storage[wr_ptr] <= {in_pc, in_inst, in_snpc}.
  - wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- id_valid = reset & (count != 0).
- Head outputs:
  - When id_valid=1: {id_pc, id_inst, id_snpc} = storage[rd_ptr].
  - When id_valid=0: id_pc=0, id_inst=NOP_INST, id_snpc=0.
- Latency: a beat pushed at edge N is visible on id_* after edge N, i.e. in cycle N+1. No same-cycle empty bypass.
- Handshake rules:
  - Head outputs stay stable while id_valid=1 and id_ready=0.
  - in_* are sampled only on push.
- Flush (priority over push and pop):
  - At the next edge: count=0, rd_ptr=wr_ptr=0.
  - The concurrent in_* beat is dropped.
  - The concurrent head is not consumed (pop suppressed).
  - id_valid=0 in the following cycle.
  - in_ready is unaffected in the flush cycle itself and is 1 in the following cycle.
- Full: in_ready=0. The fetch stage holds its PC. A pop in the full cycle frees one slot, and in_ready=1 the next cycle.
- Empty with id_ready=1: no pop, no underflow, pointers unchanged.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro IF_ID_BUFFER_PERF_EN.
- Defined:
  - Adds output ports perf_flush_cnt (32) and perf_full_cnt (32).
  - perf_flush_cnt increments on every cycle with flush=1 and reset=1.
  - perf_full_cnt increments on every cycle with in_valid=1 and in_ready=0 and reset=1.
  - Both counters clear to 0 on reset and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1. Then in_ready=0, id_valid=0, id_inst=32'h00000013. On release, in_ready=1 in the first cycle.
- Single beat: push pc=0x0, inst=0x00500093, snpc=0x4 with id_ready=0. Next cycle id_valid=1 and id_* = {0x0, 0x00500093, 0x4}, held stable for 3 cycles. Pulse id_ready=1; next cycle id_valid=0.
- Fill and wrap (DEPTH=2):
  - Push pc 0x0 and 0x4 with id_ready=0. After the second push, in_ready=0.
  - With in_valid=1 held during full, pc 0x8 is not accepted.
  - Then set id_ready=1 and stream 10 beats. Decode sees pc 0x0, 0x4, ..., 0x24 in order, no duplicates or gaps.
- Simultaneous push and pop at count=1: count stays 1, and the head advances to the new beat next cycle.
- Flush with a push and pop in the same cycle, with 2 entries held (pc 0x10, 0x14) and an incoming pc 0x18:
  - Next cycle id_valid=0, count=0; 0x18 is never presented.
  - A following push of pc 0x40 appears as the head one cycle later.
- PERF (macro defined): 4 full-stall cycles and 2 flush cycles give perf_full_cnt=4 and perf_flush_cnt=2. Reset returns both to 0.

Source files
------------

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Decoupling instruction buffer between fetch and decode.
//                Each fetch beat {pc, inst, snpc} is captured in a small FIFO.
//                The oldest entry is presented to decode over a valid/ready
//                handshake. A flush discards every buffered beat.
//                Optional macro IF_ID_BUFFER_PERF_EN adds flush and
//                full-stall performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_snpc,
   input  logic        flush,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_snpc
`ifdef IF_ID_BUFFER_PERF_EN
   ,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_full_cnt
`endif
);

   localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [95:0]   mem_q [DEPTH];
   logic [95:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          push;
   logic          pop;

   // Handshake qualifiers; flush suppresses both the incoming beat and the pop
   always_comb begin
      in_ready = reset & (count_q != FULL_COUNT);
      id_valid = reset & (count_q != '0);
      push     = in_valid & in_ready & ~flush;
      pop      = id_valid & id_ready & ~flush;
   end

   // Next-state for pointers, occupancy and storage
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {in_pc, in_inst, in_snpc};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless until written, so no reset
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   // Head presentation; an empty buffer shows a harmless NOP
   always_comb begin
      id_pc   = '0;
      id_inst = NOP_INST;
      id_snpc = '0;
      if (id_valid) begin
         {id_pc, id_inst, id_snpc} = mem_q[rd_ptr_q];
      end
   end

`ifdef IF_ID_BUFFER_PERF_EN
   logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
   logic [31:0] perf_full_cnt_q,  perf_full_cnt_d;

   // Count flush cycles and cycles where fetch offers a beat but is stalled
   always_comb begin
      perf_flush_cnt_d = perf_flush_cnt_q;
      perf_full_cnt_d  = perf_full_cnt_q;
      if (flush) begin
         perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
      end
      if (in_valid && !in_ready) begin
         perf_full_cnt_d = perf_full_cnt_q + 32'd1;
      end
   end

   // Performance counter registers, cleared by reset, wrapping naturally
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_flush_cnt_q <= '0;
         perf_full_cnt_q  <= '0;
      end else begin
         perf_flush_cnt_q <= perf_flush_cnt_d;
         perf_full_cnt_q  <= perf_full_cnt_d;
      end
   end

   assign perf_flush_cnt = perf_flush_cnt_q;
   assign perf_full_cnt  = perf_full_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Self-checking bench for if_id_buffer. A queue-based model of
//                the FIFO tracks expected contents; directed scenarios check
//                against literal values, and a random phase checks against
//                the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic [31:0] in_snpc;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [31:0] id_snpc;
`ifdef IF_ID_BUFFER_PERF_EN
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_full_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [95:0] q[$];
   int          m_flush = 0;
   int          m_full  = 0;

   if_id_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pc    (in_pc),
      .in_inst  (in_inst),
      .in_snpc  (in_snpc),
      .flush    (flush),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_snpc  (id_snpc)
`ifdef IF_ID_BUFFER_PERF_EN
      ,
      .perf_flush_cnt (perf_flush_cnt),
      .perf_full_cnt  (perf_full_cnt)
`endif
   );

   always #5 clock = ~clock;

   function automatic bit m_in_ready();
      return (reset === 1'b1) && (q.size() < DEPTH);
   endfunction

   function automatic bit m_id_valid();
      return (reset === 1'b1) && (q.size() != 0);
   endfunction

   // Advance one clock while applying the FIFO rules to the model queue
   task automatic tick();
      bit          push;
      bit          pop;
      logic [95:0] beat;
      push = in_valid && m_in_ready() && !flush;
      pop  = m_id_valid() && id_ready && !flush;
      beat = {in_pc, in_inst, in_snpc};
      if (reset && flush) m_flush++;
      if (reset && in_valid && !m_in_ready()) m_full++;
      @(posedge clock);
      if (!reset || flush) begin
         q.delete();
         if (!reset) begin
            m_flush = 0;
            m_full  = 0;
         end
      end else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(beat);
      end
      #1;
   endtask

   task automatic drive_beat(input logic [31:0] pc, input logic [31:0] inst);
      in_pc   = pc;
      in_inst = inst;
      in_snpc = pc + 32'd4;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b1; flush = 1'b0; id_ready = 1'b0;
      drive_beat(32'h0, 32'h00500093);
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      total++;
      if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid: got %b exp 0", id_valid); end
      total++;
      if (id_inst !== NOP) begin bad++; $display("FAIL reset_id_inst: got %h exp %h", id_inst, NOP); end
      reset = 1'b1; in_valid = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
      tick();
   endtask

   task automatic test_single_beat();
      in_valid = 1'b1; id_ready = 1'b0;
      drive_beat(32'h0, 32'h00500093);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h00500093 || id_snpc !== 32'h4) begin
            bad++;
            $display("FAIL single_head[%0d]: got v=%b %h/%h/%h exp v=1 0/00500093/4", i, id_valid, id_pc, id_inst, id_snpc);
         end
         tick();
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      total++;
      if (id_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b exp 0", id_valid); end
   endtask

   task automatic test_fill_wrap();
      logic [31:0] got[$];
      logic [31:0] next_pc;
      bit          acc;
      id_ready = 1'b0; in_valid = 1'b1;
      drive_beat(32'h0, 32'h1000_0013); tick();
      drive_beat(32'h4, 32'h1000_0413); tick();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
      drive_beat(32'h8, 32'h1000_0813);
      tick(); tick();
      total++;
      if (in_ready !== 1'b0 || id_pc !== 32'h0) begin
         bad++; $display("FAIL full_hold: got rdy=%b pc=%h exp rdy=0 pc=0", in_ready, id_pc);
      end
      id_ready = 1'b1;
      next_pc  = 32'h8;
      for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
         in_valid = (next_pc <= 32'h24);
         drive_beat(next_pc, 32'h1000_0013 | (next_pc << 8));
         #1;
         acc = in_valid && in_ready;
         if (id_valid && id_ready) got.push_back(id_pc);
         tick();
         if (acc) next_pc += 32'd4;
      end
      in_valid = 1'b0;
      total++;
      if (got.size() != 10) begin bad++; $display("FAIL stream_count: got %0d exp 10", got.size()); end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         total++;
         if (got[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, got[i], 32'(4 * i)); end
      end
      for (int i = 0; i < 3; i++) tick();
      id_ready = 1'b0;
   endtask

   task automatic test_push_pop();
      in_valid = 1'b1; id_ready = 1'b0;
      drive_beat(32'h100, 32'hAAAA_0013); tick();
      id_ready = 1'b1;
      drive_beat(32'h104, 32'hBBBB_0013); tick();
      in_valid = 1'b0; id_ready = 1'b0;
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h104 || id_inst !== 32'hBBBB_0013 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL push_pop_head: got v=%b pc=%h inst=%h rdy=%b exp v=1 pc=104 inst=bbbb0013 rdy=1", id_valid, id_pc, id_inst, in_ready);
      end
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      total++;
      if (id_valid !== 1'b0) begin bad++; $display("FAIL push_pop_drain: got %b exp 0", id_valid); end
   endtask

   task automatic test_flush();
      in_valid = 1'b1; id_ready = 1'b0;
      drive_beat(32'h10, 32'h0000_1013); tick();
      drive_beat(32'h14, 32'h0000_1413); tick();
      drive_beat(32'h18, 32'h0000_1813);
      id_ready = 1'b1; flush = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle_rdy: got %b exp 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      total++;
      if (id_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL after_flush: got v=%b rdy=%b exp v=0 rdy=1", id_valid, in_ready);
      end
      in_valid = 1'b1; id_ready = 1'b0;
      drive_beat(32'h40, 32'h0000_4013); tick();
      in_valid = 1'b0;
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_snpc !== 32'h44) begin
         bad++; $display("FAIL flush_refill: got v=%b pc=%h snpc=%h exp v=1 pc=40 snpc=44", id_valid, id_pc, id_snpc);
      end
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      total++;
      if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_no_stale: got v=%b pc=%h exp v=0", id_valid, id_pc); end
   endtask

   task automatic test_random();
      logic [95:0] exp_head;
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 59) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         in_valid = $urandom_range(0, 2) != 0;
         id_ready = $urandom_range(0, 2) != 0;
         in_pc    = $urandom; in_inst = $urandom; in_snpc = $urandom;
         #1;
         total++;
         if (in_ready !== m_in_ready() || id_valid !== m_id_valid()) begin
            bad++;
            $display("FAIL rand_flags[%0d]: got rdy=%b v=%b exp rdy=%b v=%b", i, in_ready, id_valid, m_in_ready(), m_id_valid());
         end
         exp_head = m_id_valid() ? q[0] : {32'h0, NOP, 32'h0};
         total++;
         if ({id_pc, id_inst, id_snpc} !== exp_head) begin
            bad++; $display("FAIL rand_head[%0d]: got %h exp %h", i, {id_pc, id_inst, id_snpc}, exp_head);
         end
         tick();
      end
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      id_ready = 1'b0;
   endtask

`ifdef IF_ID_BUFFER_PERF_EN
   task automatic test_perf();
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
      tick();
      reset = 1'b1;
      in_valid = 1'b1;
      drive_beat(32'h200, 32'h13); tick();
      drive_beat(32'h204, 32'h13); tick();
      drive_beat(32'h208, 32'h13);
      for (int i = 0; i < 4; i++) tick();
      in_valid = 1'b0; flush = 1'b1;
      tick(); tick();
      flush = 1'b0;
      total++;
      if (perf_full_cnt !== 32'(m_full) || perf_full_cnt !== 32'd4) begin
         bad++; $display("FAIL perf_full: got %0d exp 4", perf_full_cnt);
      end
      total++;
      if (perf_flush_cnt !== 32'(m_flush) || perf_flush_cnt !== 32'd2) begin
         bad++; $display("FAIL perf_flush: got %0d exp 2", perf_flush_cnt);
      end
      reset = 1'b0; tick(); reset = 1'b1;
      total++;
      if (perf_full_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         bad++; $display("FAIL perf_reset: got full=%0d flush=%0d exp 0/0", perf_full_cnt, perf_flush_cnt);
      end
      tick();
   endtask
`endif

   initial begin
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
      in_pc = '0; in_inst = '0; in_snpc = '0;
      test_reset();
      test_single_beat();
      test_fill_wrap();
      test_push_pop();
      test_flush();
      test_random();
`ifdef IF_ID_BUFFER_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
